// File: rtl/riscv_pkg.sv
// Shared RV32I core types: next-PC selector encoding (matches the control
// decoder), fetch FSM states and the reset-time instruction.
package riscv_pkg;

  typedef enum logic [1:0] {
    NPC_SEQ    = 2'b00,
    NPC_JALR   = 2'b01,
    NPC_BRANCH = 2'b10,
    NPC_JAL    = 2'b11
  } next_pc_sel_e;

  typedef enum logic [2:0] {
    FS_IDLE,
    FS_REQ,
    FS_WAIT,
    FS_HOLD,
    FS_TRAP
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection for sequential, JALR, branch and JAL flow.
module next_pc_calc
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic [1:0]      selector,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] immediate,
  input  logic [XLEN-1:0] alu_result,
  output logic [XLEN-1:0] next_pc
);

  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] rel_pc;
  next_pc_sel_e    sel;

  always_comb begin
    seq_pc = pc + XLEN'(4);
    rel_pc = pc + immediate;
    sel    = next_pc_sel_e'(selector);
    unique case (sel)
      NPC_SEQ:    next_pc = seq_pc;
      NPC_JALR:   next_pc = alu_result & ~XLEN'(1);
      NPC_BRANCH: next_pc = branch_taken ? rel_pc : seq_pc;
      NPC_JAL:    next_pc = rel_pc;
      default:    next_pc = seq_pc;
    endcase
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Multi-cycle RV32I fetch stage: owns the PC, issues one outstanding imem
// request at a time, holds the instruction until retired, traps on misalignment.
module instruction_fetch_unit
  import riscv_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            instr_valid,
  output logic [31:0]     instruction,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus_4,
  input  logic            instr_ready,
  input  logic [1:0]      next_pc_selector,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] immediate,
  input  logic [XLEN-1:0] alu_result,
  output logic            misaligned,
  output logic [XLEN-1:0] bad_addr
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic            req_valid_q, req_valid_d;
  logic            instr_valid_q, instr_valid_d;
  logic            misaligned_q, misaligned_d;
  logic [XLEN-1:0] bad_addr_q, bad_addr_d;
  logic [XLEN-1:0] next_pc;

  next_pc_calc #(
    .XLEN(XLEN)
  ) u_next_pc_calc (
    .pc          (pc_q),
    .selector    (next_pc_selector),
    .branch_taken(branch_taken),
    .immediate   (immediate),
    .alu_result  (alu_result),
    .next_pc     (next_pc)
  );

  // Valid outputs are registered alongside the state transition so they
  // always match the state being entered.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    req_valid_d   = req_valid_q;
    instr_valid_d = instr_valid_q;
    misaligned_d  = misaligned_q;
    bad_addr_d    = bad_addr_q;
    case (state_q)
      FS_IDLE: begin
        state_d     = FS_REQ;
        req_valid_d = 1'b1;
      end
      FS_REQ: begin
        if (imem_req_ready) begin
          state_d     = FS_WAIT;
          req_valid_d = 1'b0;
        end
      end
      FS_WAIT: begin
        if (imem_rsp_valid) begin
          state_d       = FS_HOLD;
          instr_d       = imem_rsp_data;
          instr_valid_d = 1'b1;
        end
      end
      FS_HOLD: begin
        if (instr_ready) begin
          instr_valid_d = 1'b0;
          if (next_pc[1:0] != 2'b00) begin
            state_d      = FS_TRAP;
            misaligned_d = 1'b1;
            bad_addr_d   = next_pc;
          end else begin
            state_d     = FS_REQ;
            pc_d        = next_pc;
            req_valid_d = 1'b1;
          end
        end
      end
      FS_TRAP: begin
        req_valid_d   = 1'b0;
        instr_valid_d = 1'b0;
      end
      default: begin
        state_d       = FS_IDLE;
        req_valid_d   = 1'b0;
        instr_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= FS_IDLE;
      pc_q          <= RESET_PC;
      instr_q       <= NOP_INSTR;
      req_valid_q   <= 1'b0;
      instr_valid_q <= 1'b0;
      misaligned_q  <= 1'b0;
      bad_addr_q    <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      req_valid_q   <= req_valid_d;
      instr_valid_q <= instr_valid_d;
      misaligned_q  <= misaligned_d;
      bad_addr_q    <= bad_addr_d;
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_addr      = pc_q;
  assign instr_valid    = instr_valid_q;
  assign instruction    = instr_q;
  assign pc             = pc_q;
  assign pc_plus_4      = pc_q + XLEN'(4);
  assign misaligned     = misaligned_q;
  assign bad_addr       = bad_addr_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: sequential fetch, backpressure,
// branch/JAL/JALR targets, wrap, stall, misaligned trap and reset mid-WAIT.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic [31:0] pc_plus_4;
  logic        instr_ready;
  logic [1:0]  next_pc_selector;
  logic        branch_taken;
  logic [31:0] immediate;
  logic [31:0] alu_result;
  logic        misaligned;
  logic [31:0] bad_addr;

  int unsigned tests_run = 0;
  int unsigned tests_failed = 0;

  always #5 clk = ~clk;

  instruction_fetch_unit #(
    .XLEN    (32),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_addr       (imem_addr),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .instr_valid     (instr_valid),
    .instruction     (instruction),
    .pc              (pc),
    .pc_plus_4       (pc_plus_4),
    .instr_ready     (instr_ready),
    .next_pc_selector(next_pc_selector),
    .branch_taken    (branch_taken),
    .immediate       (immediate),
    .alu_result      (alu_result),
    .misaligned      (misaligned),
    .bad_addr        (bad_addr)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Bounded wait for a request, accept it, answer one cycle later.
  task automatic fetch(input logic [31:0] exp_addr, input logic [31:0] word);
    int unsigned n = 0;
    while (imem_req_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("req_valid_seen", {31'b0, imem_req_valid}, 32'h1);
    chk("imem_addr", imem_addr, exp_addr);
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    chk("req_accepted", {31'b0, imem_req_valid}, 32'h0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = word;
    step();
    imem_rsp_valid = 1'b0;
    chk("hold_valid", {31'b0, instr_valid}, 32'h1);
    chk("hold_instr", instruction, word);
    chk("hold_pc", pc, exp_addr);
  endtask

  task automatic retire(input logic [1:0] sel, input logic bt,
                        input logic [31:0] imm, input logic [31:0] alu);
    next_pc_selector = sel;
    branch_taken     = bt;
    immediate        = imm;
    alu_result       = alu;
    instr_ready      = 1'b1;
    step();
    instr_ready      = 1'b0;
    chk("valid_drop", {31'b0, instr_valid}, 32'h0);
  endtask

  initial begin
    logic [31:0] addr;
    rst = 1'b1;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    instr_ready    = 1'b1;
    next_pc_selector = 2'b00;
    branch_taken   = 1'b0;
    immediate      = '0;
    alu_result     = '0;
    repeat (2) step();

    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
    chk("rst_instr_valid", {31'b0, instr_valid}, 32'h0);
    chk("rst_instruction", instruction, 32'h0000_0013);
    chk("rst_pc", pc, 32'h0);
    chk("rst_misaligned", {31'b0, misaligned}, 32'h0);
    chk("rst_bad_addr", bad_addr, 32'h0);

    // Zero-wait memory with instr_ready held: one retirement every 3 cycles.
    rst = 1'b0;
    step();
    addr = 32'h0;
    for (int i = 0; i < 3; i++) begin
      chk("seq_req_valid", {31'b0, imem_req_valid}, 32'h1);
      chk("seq_addr", imem_addr, addr);
      chk("seq_iv_req", {31'b0, instr_valid}, 32'h0);
      step();
      chk("seq_wait_req", {31'b0, imem_req_valid}, 32'h0);
      chk("seq_iv_wait", {31'b0, instr_valid}, 32'h0);
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'h0010_0093 + addr;
      step();
      imem_rsp_valid = 1'b0;
      chk("seq_iv_hold", {31'b0, instr_valid}, 32'h1);
      chk("seq_instr", instruction, 32'h0010_0093 + addr);
      chk("seq_pc_plus_4", pc_plus_4, addr + 32'h4);
      step();
      addr = addr + 32'h4;
    end
    instr_ready    = 1'b0;
    imem_req_ready = 1'b0;

    fetch(32'h0000_000C, 32'h1111_0013);
    retire(2'b00, 1'b0, 32'h0, 32'h0);

    // Backpressure at 0x10.
    for (int i = 0; i < 5; i++) begin
      chk("bp_req_valid", {31'b0, imem_req_valid}, 32'h1);
      chk("bp_addr", imem_addr, 32'h0000_0010);
      step();
    end
    fetch(32'h0000_0010, 32'h2222_0013);
    retire(2'b11, 1'b0, 32'h0000_0010, 32'h0);

    fetch(32'h0000_0020, 32'h3333_0063);
    retire(2'b10, 1'b1, 32'hFFFF_FFF0, 32'h0);
    fetch(32'h0000_0010, 32'h4444_0013);
    retire(2'b11, 1'b0, 32'h0000_0010, 32'h0);
    fetch(32'h0000_0020, 32'h3333_0063);
    retire(2'b10, 1'b0, 32'hFFFF_FFF0, 32'h0);
    fetch(32'h0000_0024, 32'h5555_0067);
    retire(2'b01, 1'b0, 32'h0, 32'h0000_0201);
    fetch(32'h0000_0200, 32'h6666_0067);
    retire(2'b01, 1'b1, 32'h0, 32'h0000_0041);
    fetch(32'h0000_0040, 32'h7777_006F);
    retire(2'b11, 1'b0, 32'h0000_0100, 32'h0);
    fetch(32'h0000_0140, 32'h8888_0013);

    // Stall in HOLD for 4 cycles.
    for (int i = 0; i < 4; i++) begin
      step();
      chk("stall_valid", {31'b0, instr_valid}, 32'h1);
      chk("stall_instr", instruction, 32'h8888_0013);
      chk("stall_pc", pc, 32'h0000_0140);
      chk("stall_no_req", {31'b0, imem_req_valid}, 32'h0);
    end
    retire(2'b01, 1'b0, 32'h0, 32'hFFFF_FFFC);
    fetch(32'hFFFF_FFFC, 32'h9999_0013);
    chk("wrap_pc_plus_4", pc_plus_4, 32'h0);
    retire(2'b00, 1'b0, 32'h0, 32'h0);
    fetch(32'h0000_0000, 32'hAAAA_0067);

    // Misaligned JALR target traps and stays put.
    retire(2'b01, 1'b0, 32'h0, 32'h0000_0103);
    chk("trap_misaligned", {31'b0, misaligned}, 32'h1);
    chk("trap_bad_addr", bad_addr, 32'h0000_0102);
    chk("trap_pc", pc, 32'h0);
    imem_req_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("trap_no_req", {31'b0, imem_req_valid}, 32'h0);
      chk("trap_no_valid", {31'b0, instr_valid}, 32'h0);
      chk("trap_sticky", {31'b0, misaligned}, 32'h1);
    end
    imem_req_ready = 1'b0;

    // Reset clears the trap.
    rst = 1'b1;
    step();
    chk("rst2_misaligned", {31'b0, misaligned}, 32'h0);
    chk("rst2_bad_addr", bad_addr, 32'h0);
    chk("rst2_instruction", instruction, 32'h0000_0013);
    rst = 1'b0;
    step();

    // Reset mid-WAIT, then a late response that must be discarded.
    chk("mw_req_valid", {31'b0, imem_req_valid}, 32'h1);
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    chk("mw_in_wait", {31'b0, imem_req_valid}, 32'h0);
    rst = 1'b1;
    #1;
    chk("mw_async_req", {31'b0, imem_req_valid}, 32'h0);
    chk("mw_async_instr", instruction, 32'h0000_0013);
    step();
    rst = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    step();
    imem_rsp_valid = 1'b0;
    chk("mw_late_instr", instruction, 32'h0000_0013);
    chk("mw_late_valid", {31'b0, instr_valid}, 32'h0);
    chk("mw_restart_req", {31'b0, imem_req_valid}, 32'h1);
    chk("mw_restart_addr", imem_addr, 32'h0);
    fetch(32'h0000_0000, 32'h0010_0093);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Fetch stage directly upstream of the control decoder in the multi-cycle RV32I core. Owns the PC, issues valid/ready requests to instruction memory, and holds the fetched word in an instruction register for the opcode/control decode path. When the core retires the instruction, it consumes the decoder's next_pc_selector, the branch outcome, the immediate and the ALU result to form the next PC. Traps on a misaligned target.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
XLEN, 32, datapath/address width; only 32 supported

Ports:
clk  in  1  core clock
rst  in  1  asynchronous active-high reset
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_addr  out  XLEN  fetch address (= pc)
imem_rsp_valid  in  1  read data valid
imem_rsp_data  in  32  fetched instruction word
instr_valid  out  1  instruction register holds a valid instruction
instruction  out  32  instruction register, feeds opcode/control decode
pc  out  XLEN  address of the held instruction
pc_plus_4  out  XLEN  pc + 4, used as the JAL/JALR link value
instr_ready  in  1  core retires the held instruction this cycle
next_pc_selector  in  2  from the control decoder: 00 seq, 01 jalr, 10 branch, 11 jal
branch_taken  in  1  branch comparator result; only used when selector = 10
immediate  in  XLEN  sign-extended immediate
alu_result  in  XLEN  ALU output; JALR target
misaligned  out  1  sticky fetch-misaligned trap flag
bad_addr  out  XLEN  offending target address, valid while misaligned=1

Behaviour:
- Reset is asynchronous and active-high: clk is the single clock; while rst=1 all state clears.
  - state=IDLE, pc=RESET_PC, instruction=32'h0000_0013 (NOP)
  - instr_valid=0, imem_req_valid=0, misaligned=0, bad_addr=0
- FSM states: IDLE, REQ, WAIT, HOLD, TRAP.
- IDLE: leaves unconditionally to REQ on the first clock after reset deasserts.
- REQ: imem_req_valid=1, imem_addr=pc. imem_addr is held stable while valid && !ready. On imem_req_ready the FSM goes to WAIT.
- WAIT: on imem_rsp_valid, instruction <= imem_rsp_data and the FSM goes to HOLD. Exactly one outstanding request is allowed.
- imem_rsp_valid is ignored in IDLE, REQ, HOLD and TRAP. A response in the same cycle as request acceptance is not legal and is ignored.
- HOLD: instr_valid=1. instruction, pc and pc_plus_4 are stable until instr_ready. On instr_ready the FSM computes next_pc:
  - 00: pc+4
  - 01: alu_result & ~32'h1
  - 10: branch_taken ? pc+immediate : pc+4
  - 11: pc+immediate
- HOLD exit: if next_pc[1:0] != 0, misaligned<=1, bad_addr<=next_pc, pc unchanged, go to TRAP. Otherwise pc<=next_pc and go to REQ.
- instr_valid deasserts the cycle after retirement.
- TRAP: sticky until rst. All request and valid outputs are 0.
- Arithmetic is modulo 2^32 with no overflow detection: 32'hFFFF_FFFC + 4 = 0.
- Throughput: with zero-wait memory (ready=1, rsp one cycle later) and instr_ready held 1, one instruction retires every 3 cycles.
- A reset asserted mid-transaction aborts it. Any late response after reset arrives outside WAIT and is discarded.
- instr_ready outside HOLD is ignored.

Decomposition:
- riscv_pkg holds:
  - next_pc_sel_e enum (NPC_SEQ=2'b00, NPC_JALR=2'b01, NPC_BRANCH=2'b10, NPC_JAL=2'b11); shared with the control decoder encoding
  - fetch_state_e enum
  - NOP_INSTR = 32'h0000_0013
- One combinational sub-module, next_pc_calc: inputs are pc, selector, branch_taken, immediate and alu_result; output is next_pc. It is reused by the verification model.

Test Plan:
- Reset and sequential fetch: rst pulse, memory ready=1 with 1-cycle response, instr_ready=1, selector=00 -> imem_addr sequence 0, 4, 8, with instr_valid every third cycle.
- Backpressure: hold imem_req_ready=0 for 5 cycles at pc=0x10 -> imem_addr=0x10 and req_valid=1 stable throughout; then one request accepted.
- Branch: at pc=0x20 with selector=10 and immediate=0xFFFF_FFF0 -> next fetch at 0x10 when branch_taken=1, at 0x24 when branch_taken=0.
- JALR and JAL:
  - selector=01, alu_result=0x0000_0103 -> fetch 0x0000_0102 -> misaligned=1, bad_addr=0x102, TRAP (no further requests until rst)
  - selector=01, alu_result=0x201 -> fetch 0x200
  - selector=11 at pc=0x40, immediate=0x100 -> fetch 0x140
- Wrap and stall: pc=0xFFFF_FFFC with selector=00 -> next fetch at 0. Holding instr_ready=0 for 4 cycles in HOLD -> instruction and pc unchanged, no new request.
- Reset mid-WAIT: assert rst during WAIT, then drive a late imem_rsp_valid -> ignored. Fetch restarts at RESET_PC and instruction reads NOP until the first response.
